cube_frame_uart_tx: RTL and testbench

- Host-side streamer: reads one cube frame (PAYLOAD_BYTES voxel bytes) from a synchronous frame RAM and serialises it over 8N1 UART as a framed packet: sync byte, payload, checksum.
- Feeds the cube controller's UART RX pin; also used as the bench/pattern-generator source for the cube receive path.

---
 rtl/cube_frame_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_cube_frame_uart_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_frame_uart_tx.sv
// Streams one cube frame from a synchronous frame RAM out over 8N1 UART.
// Packet on the line: sync byte, PAYLOAD_BYTES voxel bytes, 8-bit payload sum.
module cube_frame_uart_tx #(
  parameter int unsigned BAUD_DIV      = 434,
  parameter int unsigned PAYLOAD_BYTES = 64,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  localparam int unsigned AW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  input  logic [7:0]    rd_data,
  output logic          txd,
  output logic          busy,
  output logic          done,
  output logic [15:0]   frame_count
);

  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam int unsigned IW = $clog2(PAYLOAD_BYTES + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] NEXT   = 3'd4;
  localparam logic [2:0] FETCH1 = 3'd5;
  localparam logic [2:0] FETCH2 = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    csum_q, csum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          csum_sent_q, csum_sent_d;
  logic [AW-1:0] rd_addr_d;
  logic          rd_en_d, txd_d, busy_d, done_d;
  logic [15:0]   frame_count_d;
  logic          bit_end;

  assign bit_end = (bit_cnt_q == BW'(BAUD_DIV - 1));

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    csum_d        = csum_q;
    idx_d         = idx_q;
    csum_sent_d   = csum_sent_q;
    rd_addr_d     = rd_addr;
    rd_en_d       = 1'b0;
    txd_d         = txd;
    busy_d        = busy;
    done_d        = 1'b0;
    frame_count_d = frame_count;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (start) begin
          busy_d      = 1'b1;
          csum_d      = 8'd0;
          idx_d       = '0;
          csum_sent_d = 1'b0;
          shreg_d     = SYNC_BYTE;
          bit_cnt_d   = '0;
          txd_d       = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          txd_d     = shreg_q[0];
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            txd_d     = shreg_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = NEXT;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      NEXT: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx_q < IW'(PAYLOAD_BYTES)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q[AW-1:0];
          state_d   = FETCH1;
        end else if (!csum_sent_q) begin
          csum_sent_d = 1'b1;
          shreg_d     = csum_q;
          txd_d       = 1'b0;
          state_d     = START;
        end else begin
          busy_d        = 1'b0;
          done_d        = 1'b1;
          frame_count_d = frame_count + 16'd1;
          state_d       = IDLE;
        end
      end
      FETCH1: state_d = FETCH2;
      FETCH2: begin
        // RAM data is valid now, one cycle after the read strobe.
        shreg_d = rd_data;
        csum_d  = csum_q + rd_data;
        idx_d   = idx_q + IW'(1);
        txd_d   = 1'b0;
        state_d = START;
      end
      default: begin
        busy_d  = 1'b0;
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'd0;
      csum_q      <= 8'd0;
      idx_q       <= '0;
      csum_sent_q <= 1'b0;
      rd_addr     <= '0;
      rd_en       <= 1'b0;
      txd         <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      csum_sent_q <= csum_sent_d;
      rd_addr     <= rd_addr_d;
      rd_en       <= rd_en_d;
      txd         <= txd_d;
      busy        <= busy_d;
      done        <= done_d;
      frame_count <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_cube_frame_uart_tx.sv
// Directed bench for cube_frame_uart_tx: decodes the UART line and checks
// framing, checksum, RAM reads, done/busy, abort, async reset and count wrap.
module tb_cube_frame_uart_tx;

  localparam int unsigned BAUD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [1:0]  rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data = 8'd0;
  logic        txd, busy, done;
  logic [15:0] frame_count;

  logic        start2, abort2;
  logic [0:0]  rd_addr2;
  logic        rd_en2;
  logic [7:0]  rd_data2 = 8'd0;
  logic        txd2, busy2, done2;
  logic [15:0] frame_count2;

  logic [7:0]  ram [4];
  logic [7:0]  ram2;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_busy_bad = 0;
  logic busy_prev = 1'b0;
  int rd_log [$];

  always #5 clk = ~clk;

  cube_frame_uart_tx #(.BAUD_DIV(4), .PAYLOAD_BYTES(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .txd(txd), .busy(busy), .done(done), .frame_count(frame_count)
  );

  cube_frame_uart_tx #(.BAUD_DIV(2), .PAYLOAD_BYTES(1), .SYNC_BYTE(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .rd_addr(rd_addr2), .rd_en(rd_en2), .rd_data(rd_data2),
    .txd(txd2), .busy(busy2), .done(done2), .frame_count(frame_count2)
  );

  // Synchronous frame RAMs: data valid the cycle after the strobe.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];
  always @(posedge clk) if (rd_en2) rd_data2 <= ram2;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      if (busy !== 1'b0 || busy_prev !== 1'b1) done_busy_bad = done_busy_bad + 1;
    end
    if (rd_en === 1'b1) rd_log.push_back(int'(rd_addr));
    busy_prev = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Call at a negedge outside a byte; returns at the negedge after the stop bit.
  task automatic rx_byte(input logic [7:0] exp, input string tag);
    int n;
    logic [7:0] b;
    logic ok, s0;
    n = 0;
    b = 8'd0;
    while (txd !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 400);
    for (int bi = 0; bi < 10; bi++) begin
      s0 = txd;
      for (int k = 1; k < BAUD; k++) begin
        @(negedge clk);
        if (txd !== s0) ok = 1'b0;
      end
      if (bi == 0 && s0 !== 1'b0) ok = 1'b0;
      if (bi >= 1 && bi <= 8) b[bi-1] = s0;
      if (bi == 9 && s0 !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    check({tag, "_val"}, 32'(b), 32'(exp));
    check({tag, "_timing"}, 32'(ok), 32'd1);
  endtask

  task automatic rx_frame(input logic [47:0] bytes, input string tag);
    for (int i = 0; i < 6; i++) rx_byte(bytes[8*i +: 8], $sformatf("%s_b%0d", tag, i));
  endtask

  initial begin
    int base_done, base_rd, lows, n;
    reset = 1'b1;
    start = 1'b0; abort = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
    ram2 = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: 01..04, checksum 0A
    base_done = done_cnt; base_rd = rd_log.size();
    pulse_start();
    check("f1_busy", 32'(busy), 32'd1);
    rx_frame(48'h0A04030201A5, "f1");
    repeat (3) @(negedge clk);
    check("f1_done_cnt", 32'(done_cnt - base_done), 32'd1);
    check("f1_done_busy", 32'(done_busy_bad), 32'd0);
    check("f1_busy_end", 32'(busy), 32'd0);
    check("f1_frame_count", 32'(frame_count), 32'd1);

    // Frame 2: all FF, checksum wraps to FC; four reads at 0..3
    ram[0] = 8'hFF; ram[1] = 8'hFF; ram[2] = 8'hFF; ram[3] = 8'hFF;
    base_rd = rd_log.size();
    pulse_start();
    rx_frame(48'hFCFFFFFFFFA5, "f2");
    repeat (3) @(negedge clk);
    check("f2_rd_cnt", 32'(rd_log.size() - base_rd), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("f2_rd_addr%0d", i),
            (base_rd + i < rd_log.size()) ? 32'(rd_log[base_rd + i]) : 32'hDEAD, 32'(i));
    check("f2_frame_count", 32'(frame_count), 32'd2);

    // Frame 3: extra start during payload byte 02 is ignored
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
    base_done = done_cnt;
    pulse_start();
    rx_byte(8'hA5, "f3_b0");
    rx_byte(8'h01, "f3_b1");
    fork
      rx_byte(8'h02, "f3_b2");
      begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    rx_byte(8'h03, "f3_b3");
    rx_byte(8'h04, "f3_b4");
    rx_byte(8'h0A, "f3_b5");
    repeat (3) @(negedge clk);
    check("f3_done_cnt", 32'(done_cnt - base_done), 32'd1);
    check("f3_frame_count", 32'(frame_count), 32'd3);

    // Frame 4: fresh start after done sends a whole packet
    pulse_start();
    rx_frame(48'h0A04030201A5, "f4");
    repeat (3) @(negedge clk);
    check("f4_frame_count", 32'(frame_count), 32'd4);

    // Abort held during payload 01: line stops after its stop bit
    base_done = done_cnt;
    pulse_start();
    rx_byte(8'hA5, "ab_b0");
    fork
      rx_byte(8'h01, "ab_b1");
      begin
        repeat (5) @(negedge clk);
        abort = 1'b1;
      end
    join
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    abort = 1'b0;
    check("ab_idle_line", 32'(lows), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_no_done", 32'(done_cnt - base_done), 32'd0);
    check("ab_frame_count", 32'(frame_count), 32'd4);

    // Async reset during bit 3 of payload byte 03
    pulse_start();
    rx_byte(8'hA5, "rs_b0");
    rx_byte(8'h01, "rs_b1");
    rx_byte(8'h02, "rs_b2");
    repeat (20) @(negedge clk);
    check("rs_pre_txd", 32'(txd), 32'd0);
    check("rs_pre_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rs_async_txd", 32'(txd), 32'd1);
    check("rs_async_busy", 32'(busy), 32'd0);
    check("rs_async_rd_en", 32'(rd_en), 32'd0);
    check("rs_async_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base_done = done_cnt;
    pulse_start();
    rx_frame(48'h0A04030201A5, "rs_f");
    repeat (3) @(negedge clk);
    check("rs_done_cnt", 32'(done_cnt - base_done), 32'd1);
    check("rs_frame_count", 32'(frame_count), 32'd1);

    // Frame counter wrap on the short-frame instance, preloaded to FFFF
    force dut2.frame_count = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut2.frame_count;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wrap_done", 32'(done2), 32'd1);
    check("wrap_frame_count", 32'(frame_count2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
